div_share_ctrl: RTL and testbench

//  Sequencing controller + arbiter sharing one iterative 8/4 shift-subtract divider

---
 rtl/div_share_ctrl.sv | 167 ++++++++++++++++
 tb/tb_div_share_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
// Round-robin arbiter + sequencer sharing one shift-subtract divider; result DW cycles after accept
// (1 cycle for divide-by-zero); response held in DONE until rsp_ready, no accepts until it retires.
module div_share_ctrl #(
  parameter int DW   = 8,
  parameter int VW   = 4,
  parameter int NREQ = 2,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_dividend,
  input  logic [NREQ*VW-1:0] req_divisor,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IW-1:0]      rsp_id,
  output logic [DW-1:0]      rsp_q,
  output logic [DW-1:0]      rsp_r,
  output logic               rsp_dz,
  output logic               busy
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t          state, state_n;
  logic            rsp_valid_n;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_found;
  logic            accept;
  logic [DW-1:0]   sel_dvd;
  logic [VW-1:0]   sel_dvs;
  logic [IW-1:0]   op_id;
  logic [VW-1:0]   op_dvs;
  logic [VW-1:0]   rem;
  logic [DW-1:0]   quo;
  logic [CW-1:0]   cnt;
  logic [VW:0]     rem_sh;
  logic [VW:0]     diff;
  logic [VW-1:0]   rem_n;
  logic [DW-1:0]   quo_n;
  logic            last_iter;

  // Round-robin search starting at rr_ptr
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(rr_ptr) + i) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == IW'(k)) begin
        sel_dvd = req_dividend[k*DW +: DW];
        sel_dvs = req_divisor[k*VW +: VW];
      end
    end
  end

  assign accept    = (state == IDLE) && gnt_found;
  assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;
  assign busy      = (state != IDLE);

  // One restoring-division step; the borrow bit of diff doubles as the compare result
  always_comb begin
    rem_sh    = {rem, quo[DW-1]};
    diff      = rem_sh - {1'b0, op_dvs};
    rem_n     = rem_sh[VW-1:0];
    quo_n     = {quo[DW-2:0], 1'b0};
    if (!diff[VW]) begin
      rem_n = diff[VW-1:0];
      quo_n = {quo[DW-2:0], 1'b1};
    end
    last_iter = (cnt == CW'(DW-1));
  end

  always_comb begin
    state_n     = state;
    rsp_valid_n = rsp_valid;
    case (state)
      IDLE: begin
        if (gnt_found) state_n = (sel_dvs == '0) ? DONE : ITER;
      end
      ITER: begin
        if (last_iter) begin
          state_n     = DONE;
          rsp_valid_n = 1'b1;
        end
      end
      DONE: begin
        // Divide-by-zero enters DONE with rsp_valid low and raises it one cycle later
        if (!rsp_valid) begin
          rsp_valid_n = 1'b1;
        end else if (rsp_ready) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
        end
      end
      default: begin
        state_n     = IDLE;
        rsp_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_n;
      rsp_valid <= rsp_valid_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      op_id  <= '0;
      op_dvs <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      rsp_id <= '0;
      rsp_q  <= '0;
      rsp_r  <= '0;
      rsp_dz <= 1'b0;
    end else if (accept) begin
      rr_ptr <= IW'((int'(gnt_idx) + 1) % NREQ);
      op_id  <= gnt_idx;
      op_dvs <= sel_dvs;
      rem    <= '0;
      quo    <= sel_dvd;
      cnt    <= '0;
      if (sel_dvs == '0) begin
        rsp_id <= gnt_idx;
        rsp_q  <= '1;
        rsp_r  <= sel_dvd;
        rsp_dz <= 1'b1;
      end
    end else if (state == ITER) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt + CW'(1);
      if (last_iter) begin
        rsp_id <= op_id;
        rsp_q  <= quo_n;
        rsp_r  <= DW'(rem_n);
        rsp_dz <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl: fixed operand vectors with hand-computed quotients.
module tb_div_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_dividend;
  logic [7:0]  req_divisor;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_id;
  logic [7:0]  rsp_q;
  logic [7:0]  rsp_r;
  logic        rsp_dz;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  div_share_ctrl #(.DW(8), .VW(4), .NREQ(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_q        (rsp_q),
    .rsp_r        (rsp_r),
    .rsp_dz       (rsp_dz),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one op on requester `who`, optionally with other requesters also valid
  task automatic do_op(input string tag, input int who, input logic [1:0] other,
                       input logic [7:0] dvd, input logic [3:0] dvs,
                       input logic [7:0] eq, input logic [7:0] er, input logic edz, input int elat);
    int n;
    req_dividend[who*8 +: 8] = dvd;
    req_divisor[who*4 +: 4]  = dvs;
    req_valid = other | (2'b01 << who);
    #1;
    n = 0;
    while (!req_ready[who] && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_grant"}, req_ready, 2'b01 << who);
    step();
    req_valid = 2'b00;
    n = 0;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_id"}, rsp_id, who);
    chk({tag, "_q"}, rsp_q, eq);
    chk({tag, "_r"}, rsp_r, er);
    chk({tag, "_dz"}, rsp_dz, edz);
    step();
    chk({tag, "_retired"}, rsp_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int g;
    int cyc;
    int last_cyc;
    int gid[4];
    logic [0:0] exp_ids[$];
    logic [0:0] eid;

    rst_n        = 1'b0;
    req_valid    = 2'b00;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = 1'b1;
    #2;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_q", rsp_q, 0);
    chk("rst_r", rsp_r, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_dz", rsp_dz, 0);
    chk("rst_ready", req_ready, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Basic divides
    do_op("t1_13_2", 0, 2'b00, 8'd13, 4'd2, 8'd6, 8'd1, 1'b0, 8);
    do_op("t2_15_4", 1, 2'b00, 8'd15, 4'd4, 8'd3, 8'd3, 1'b0, 8);
    do_op("t2_255_1", 0, 2'b00, 8'd255, 4'd1, 8'd255, 8'd0, 1'b0, 8);
    do_op("t2_0_15", 0, 2'b00, 8'd0, 4'd15, 8'd0, 8'd0, 1'b0, 8);
    do_op("t3_7_0", 0, 2'b00, 8'd7, 4'd0, 8'hFF, 8'd7, 1'b1, 1);

    // Response backpressure: 9/3 on req0 held for 5 cycles
    rsp_ready = 1'b0;
    req_dividend = {8'd50, 8'd9};
    req_divisor  = {4'd7, 4'd3};
    req_valid = 2'b01;
    #1;
    chk("t5_grant0", req_ready, 2'b01);
    step();
    req_valid = 2'b11;
    n = 0;
    while (!rsp_valid && n < 40) begin
      chk("t5_iter_noready", req_ready, 0);
      step();
      n++;
    end
    chk("t5_lat", n, 8);
    for (int c = 1; c <= 5; c++) begin
      chk("t5_hold_valid", rsp_valid, 1);
      chk("t5_hold_q", rsp_q, 3);
      chk("t5_hold_r", rsp_r, 0);
      chk("t5_hold_id", rsp_id, 0);
      chk("t5_hold_noready", req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t5_retire_valid", rsp_valid, 1);
    chk("t5_retire_noready", req_ready, 0);
    step();
    chk("t5_after_valid", rsp_valid, 0);
    chk("t5_after_grant", req_ready, 2'b10);
    step();
    chk("t5_accept_busy", busy, 1);
    req_valid = 2'b00;
    n = 0;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    chk("t5_req1_id", rsp_id, 1);
    chk("t5_req1_q", rsp_q, 7);
    chk("t5_req1_r", rsp_r, 1);
    step();
    chk("t5_req1_retired", rsp_valid, 0);

    // Both requesters continuously valid from reset
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    req_dividend = {8'd100, 8'd20};
    req_divisor  = {4'd10, 4'd3};
    req_valid    = 2'b11;
    #1;
    g = 0;
    cyc = 0;
    last_cyc = 0;
    while (g < 4 && cyc < 200) begin
      chk("t4_onehot", ($countones(req_ready) <= 1), 1);
      if (busy) chk("t4_ready_busy", req_ready, 0);
      if (rsp_valid && exp_ids.size() > 0) begin
        eid = exp_ids.pop_front();
        chk("t4_rsp_id", rsp_id, eid);
        chk("t4_rsp_q", rsp_q, (eid == 1'b1) ? 10 : 6);
      end
      if (req_ready != 2'b00) begin
        gid[g] = int'(req_ready[1]);
        exp_ids.push_back(req_ready[1]);
        if (g > 0) chk("t4_spacing", cyc - last_cyc, 10);
        last_cyc = cyc;
        g++;
      end
      step();
      cyc++;
    end
    req_valid = 2'b00;
    chk("t4_grant_count", g, 4);
    chk("t4_g0", gid[0], 0);
    chk("t4_g1", gid[1], 1);
    chk("t4_g2", gid[2], 0);
    chk("t4_g3", gid[3], 1);
    n = 0;
    while (busy && n < 40) begin
      if (rsp_valid && exp_ids.size() > 0) begin
        eid = exp_ids.pop_front();
        chk("t4_drain_id", rsp_id, eid);
        chk("t4_drain_q", rsp_q, (eid == 1'b1) ? 10 : 6);
      end
      step();
      n++;
    end
    chk("t4_drained", busy, 0);

    // Reset mid-iteration of 200/9 on req0 (leaves rr_ptr at 1 if not cleared)
    req_dividend[7:0] = 8'd200;
    req_divisor[3:0]  = 4'd9;
    req_valid = 2'b01;
    #1;
    chk("t6_pre_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) step();
    chk("t6_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", rsp_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_q", rsp_q, 0);
    chk("t6_rst_r", rsp_r, 0);
    chk("t6_rst_id", rsp_id, 0);
    chk("t6_rst_dz", rsp_dz, 0);
    chk("t6_rst_ready", req_ready, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_no_rsp", rsp_valid, 0);
    do_op("t6_200_9", 0, 2'b10, 8'd200, 4'd9, 8'd22, 8'd2, 1'b0, 8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
